// File: rtl/elastic_pipe_reg_pkg.sv
// Shared constants and types for the inter-stage elastic pipeline registers.
// Latency: n/a (types, constants and a compile-time helper only).
// Backpressure: n/a.
package elastic_pipe_reg_pkg;

  // Deepest pipe a single elastic register instance may be built with.
  localparam int MAX_PIPE_DEPTH = 4;

  // Default field widths used by the ID->EX and EX->MEM boundaries.
  localparam int DEF_CTRL_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 128;

  // Bit offsets of the processor's stage control flags inside the ctrl field.
  // EX_CMD is a 2-bit field whose LSB sits at CTRL_EX_CMD.
  typedef enum int unsigned {
    CTRL_MEM_R_EN = 0,
    CTRL_MEM_W_EN = 1,
    CTRL_WB_EN    = 2,
    CTRL_IMM      = 3,
    CTRL_B        = 4,
    CTRL_S        = 5,
    CTRL_EX_CMD   = 6
  } ctrl_bit_e;

  // Structured view of the default-width ctrl field, same layout as the offsets.
  typedef struct packed {
    logic [1:0] ex_cmd;
    logic       s;
    logic       b;
    logic       imm;
    logic       wb_en;
    logic       mem_w_en;
    logic       mem_r_en;
  } stage_ctrl_t;

  // True when a requested slot count can be built.
  function automatic bit depth_legal(input int depth);
    return (depth >= 1) && (depth <= MAX_PIPE_DEPTH);
  endfunction

endpackage

// File: rtl/elastic_pipe_reg_pipe_slot.sv
// One elastic pipe slot holding valid/ctrl/data for a single entry.
// Latency: 1 cycle from load to the slot outputs.
// Backpressure: holds all fields when load=0; flush empties the slot and zeroes ctrl.
module elastic_pipe_reg_pipe_slot
  import elastic_pipe_reg_pkg::*;
#(
  parameter int CTRL_WIDTH = DEF_CTRL_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  flush,
  input  logic                  src_vld,
  input  logic [CTRL_WIDTH-1:0] src_ctrl,
  input  logic [DATA_WIDTH-1:0] src_dat,
  output logic                  slot_vld,
  output logic [CTRL_WIDTH-1:0] slot_ctrl,
  output logic [DATA_WIDTH-1:0] slot_dat
);

  logic                  vld_q,  vld_d;
  logic [CTRL_WIDTH-1:0] ctrl_q, ctrl_d;
  logic [DATA_WIDTH-1:0] dat_q,  dat_d;

  // Next-state: flush empties the slot, otherwise load copies the source entry.
  // Payload only moves when a real entry arrives, so bubbles leave it untouched.
  always_comb begin
    vld_d  = vld_q;
    ctrl_d = ctrl_q;
    dat_d  = dat_q;
    if (flush) begin
      vld_d  = 1'b0;
      ctrl_d = '0;
    end else if (load) begin
      vld_d  = src_vld;
      ctrl_d = src_vld ? src_ctrl : '0;
      if (src_vld) begin
        dat_d = src_dat;
      end
    end
  end

  // Slot state registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q  <= 1'b0;
      ctrl_q <= '0;
      dat_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      ctrl_q <= ctrl_d;
      dat_q  <= dat_d;
    end
  end

  assign slot_vld  = vld_q;
  assign slot_ctrl = ctrl_q;
  assign slot_dat  = dat_q;

endmodule

// File: rtl/elastic_pipe_reg.sv
// DEPTH-slot elastic pipeline register with valid/ready on both sides, flush and occupancy.
// Latency: DEPTH cycles from in handshake to out_valid on an empty pipe; 1 entry/cycle throughput.
// Backpressure: combinational ready chain; empty slots always accept so bubbles collapse.
module elastic_pipe_reg
  import elastic_pipe_reg_pkg::*;
#(
  parameter int CTRL_WIDTH = DEF_CTRL_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = 1,
  parameter int OCC_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [OCC_WIDTH-1:0]  occupancy
);

  if (!depth_legal(DEPTH)) begin : g_bad_depth
    $error("elastic_pipe_reg: DEPTH=%0d outside 1..%0d", DEPTH, MAX_PIPE_DEPTH);
  end

  logic [DEPTH-1:0]      slot_vld;
  logic [DEPTH-1:0]      rdy;
  logic                  rdy_chain;
  logic [CTRL_WIDTH-1:0] slot_ctrl [DEPTH];
  logic [DATA_WIDTH-1:0] slot_dat  [DEPTH];
  logic [OCC_WIDTH-1:0]  occ_cnt;

  // Ready ripples back from the output: a slot can load if it is empty or its successor moves.
  always_comb begin
    rdy       = '0;
    rdy_chain = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      rdy_chain = !slot_vld[i] | rdy_chain;
      rdy[i]    = rdy_chain;
    end
  end

  // Slot 0 is fed from the input port, every later slot from its predecessor.
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic                  src_vld;
    logic [CTRL_WIDTH-1:0] src_ctrl;
    logic [DATA_WIDTH-1:0] src_dat;

    if (i == 0) begin : g_head
      assign src_vld  = in_valid;
      assign src_ctrl = in_ctrl;
      assign src_dat  = in_data;
    end else begin : g_link
      assign src_vld  = slot_vld[i-1];
      assign src_ctrl = slot_ctrl[i-1];
      assign src_dat  = slot_dat[i-1];
    end

    elastic_pipe_reg_pipe_slot #(
      .CTRL_WIDTH (CTRL_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (rdy[i]),
      .flush     (flush),
      .src_vld   (src_vld),
      .src_ctrl  (src_ctrl),
      .src_dat   (src_dat),
      .slot_vld  (slot_vld[i]),
      .slot_ctrl (slot_ctrl[i]),
      .slot_dat  (slot_dat[i])
    );
  end

  // Occupancy is the population count of the registered valid bits.
  always_comb begin
    occ_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_cnt = occ_cnt + OCC_WIDTH'(slot_vld[i]);
    end
  end

  // A flush swallows the incoming entry, so the input is always ready during it,
  // and the output is masked so nothing leaves in the flush cycle.
  assign in_ready  = rdy[0] | flush;
  assign out_valid = slot_vld[DEPTH-1] & ~flush;
  assign out_ctrl  = slot_ctrl[DEPTH-1];
  assign out_data  = slot_dat[DEPTH-1];
  assign occupancy = occ_cnt;

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Bench for elastic_pipe_reg: four instances (DEPTH 1..4) exercised one at a time.
// Latency: n/a.
// Backpressure: driven directly by the stimulus through out_ready.
module tb_elastic_pipe_reg;

  typedef enum logic [3:0] {
    S_IN_RDY, S_OUT_VLD, S_OCC, S_OUT_CTRL, S_OUT_DATA, S_SB_LEFT, S_NOUT
  } sig_e;

  typedef struct packed {
    logic [1:0]   dut;
    sig_e         sig;
    logic [127:0] val;
  } exp_t;

  typedef struct packed {
    logic [7:0]   c;
    logic [127:0] d;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [3:0]   flush, in_valid, out_ready;
  logic [3:0]   in_ready, out_valid;
  logic [7:0]   in_ctrl  [4];
  logic [127:0] in_data  [4];
  logic [7:0]   out_ctrl [4];
  logic [127:0] out_data [4];
  logic [2:0]   occ      [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int D  = g + 1;
    localparam int OW = $clog2(D + 1);
    logic [OW-1:0] occ_w;

    elastic_pipe_reg #(
      .CTRL_WIDTH (8),
      .DATA_WIDTH (128),
      .DEPTH      (D)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush[g]),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_ctrl   (in_ctrl[g]),
      .in_data   (in_data[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_ctrl  (out_ctrl[g]),
      .out_data  (out_data[g]),
      .occupancy (occ_w)
    );

    assign occ[g] = 3'(occ_w);
  end

  logic [1:0] sel;
  exp_t       exq[$];
  ent_t       sb[$];
  int         errors = 0;
  int         checks = 0;
  int         n_out  = 0;
  int         n_exp  = 0;
  exp_t       mon_x;
  ent_t       mon_e;
  logic [127:0] mon_act;

  function automatic string sig_name(input sig_e s);
    case (s)
      S_IN_RDY:   return "in_ready";
      S_OUT_VLD:  return "out_valid";
      S_OCC:      return "occupancy";
      S_OUT_CTRL: return "out_ctrl";
      S_OUT_DATA: return "out_data";
      S_SB_LEFT:  return "entries_left";
      default:    return "outputs_seen";
    endcase
  endfunction

  // Monitor: state expectations first, then the output scoreboard, then input capture.
  always @(negedge clk) begin
    while (exq.size() > 0) begin
      mon_x = exq.pop_front();
      case (mon_x.sig)
        S_IN_RDY:   mon_act = 128'(in_ready[mon_x.dut]);
        S_OUT_VLD:  mon_act = 128'(out_valid[mon_x.dut]);
        S_OCC:      mon_act = 128'(occ[mon_x.dut]);
        S_OUT_CTRL: mon_act = 128'(out_ctrl[mon_x.dut]);
        S_OUT_DATA: mon_act = out_data[mon_x.dut];
        S_SB_LEFT:  mon_act = 128'(sb.size());
        default:    mon_act = 128'(n_out);
      endcase
      checks++;
      if (mon_act !== mon_x.val) begin
        errors++;
        $display("FAIL %s dut%0d: actual=%0h required=%0h",
                 sig_name(mon_x.sig), mon_x.dut, mon_act, mon_x.val);
      end
    end
    if (out_valid[sel] && out_ready[sel]) begin
      n_out++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output dut%0d: actual ctrl=%0h data=%0h required none",
                 sel, out_ctrl[sel], out_data[sel]);
      end else begin
        mon_e = sb.pop_front();
        if (out_ctrl[sel] !== mon_e.c || out_data[sel] !== mon_e.d) begin
          errors++;
          $display("FAIL sb_entry dut%0d: actual ctrl=%0h data=%0h required ctrl=%0h data=%0h",
                   sel, out_ctrl[sel], out_data[sel], mon_e.c, mon_e.d);
        end
      end
    end
    if (flush[sel]) begin
      sb.delete();
    end else if (in_valid[sel] && in_ready[sel]) begin
      sb.push_back({in_ctrl[sel], in_data[sel]});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic exd(input logic [1:0] d, input sig_e s, input logic [127:0] v);
    exp_t t;
    t.dut = d;
    t.sig = s;
    t.val = v;
    exq.push_back(t);
  endtask

  task automatic ex(input sig_e s, input logic [127:0] v);
    exd(sel, s, v);
  endtask

  task automatic drv(input logic v, input logic [7:0] c, input logic [127:0] d,
                     input logic ordy, input logic fl);
    in_valid[sel]  = v;
    in_ctrl[sel]   = c;
    in_data[sel]   = d;
    out_ready[sel] = ordy;
    flush[sel]     = fl;
  endtask

  task automatic finish_test(input int added);
    n_exp += added;
    cyc();
    ex(S_NOUT, 128'(n_exp));
    ex(S_SB_LEFT, 0);
  endtask

  initial begin
    rst       = 1'b0;
    flush     = '0;
    in_valid  = '0;
    out_ready = '0;
    sel       = 2'd0;
    for (int g = 0; g < 4; g++) begin
      in_ctrl[g] = '0;
      in_data[g] = '0;
    end
    #1;
    // Reset state of every instance.
    for (int g = 0; g < 4; g++) begin
      exd(2'(g), S_OUT_VLD, 0);
      exd(2'(g), S_OCC, 0);
      exd(2'(g), S_IN_RDY, 1);
      exd(2'(g), S_OUT_CTRL, 0);
      exd(2'(g), S_OUT_DATA, 0);
    end
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;

    // DEPTH=2: basic latency and burst occupancy 1,2,1,0.
    sel = 2'd1;
    cyc();
    drv(1, 'h5A, 'h1234, 1, 0); ex(S_IN_RDY, 1); ex(S_OUT_VLD, 0); ex(S_OCC, 0);
    cyc();
    drv(1, 'hC3, 'hBEEF, 1, 0); ex(S_OCC, 1); ex(S_OUT_VLD, 0);
    cyc();
    drv(0, 0, 0, 1, 0); ex(S_OCC, 2); ex(S_OUT_VLD, 1); ex(S_OUT_CTRL, 'h5A); ex(S_OUT_DATA, 'h1234);
    cyc();
    ex(S_OCC, 1); ex(S_OUT_CTRL, 'hC3); ex(S_OUT_DATA, 'hBEEF);
    cyc();
    ex(S_OCC, 0); ex(S_OUT_VLD, 0); ex(S_OUT_CTRL, 0);
    finish_test(2);

    // DEPTH=3: stall with continuous input, exactly three accepts, then drain A,B,C.
    sel = 2'd2;
    cyc();
    for (int k = 0; k < 5; k++) begin
      drv(1, 8'(8'hA0 + (k < 3 ? k : 3)), 128'(128'hD000 + (k < 3 ? k : 3)), 0, 0);
      ex(S_IN_RDY, 128'(k < 3));
      cyc();
    end
    drv(0, 0, 0, 1, 0); ex(S_OCC, 3); ex(S_OUT_VLD, 1); ex(S_OUT_CTRL, 'hA0);
    cyc(); ex(S_OUT_CTRL, 'hA1);
    cyc(); ex(S_OUT_CTRL, 'hA2); ex(S_OUT_DATA, 'hD002);
    cyc(); ex(S_OCC, 0); ex(S_OUT_VLD, 0);
    finish_test(3);

    // DEPTH=3: bubble collapse behind a stalled head entry.
    cyc();
    drv(1, 'hB0, 'hE0, 0, 0); ex(S_IN_RDY, 1);
    cyc();
    drv(0, 0, 0, 0, 0);
    cyc();
    cyc();
    ex(S_OUT_VLD, 1); ex(S_OCC, 1); ex(S_OUT_CTRL, 'hB0);
    drv(1, 'hB1, 'hE1, 0, 0); ex(S_IN_RDY, 1);
    cyc();
    drv(0, 0, 0, 0, 0); ex(S_OCC, 2);
    cyc();
    drv(1, 'hB2, 'hE2, 0, 0); ex(S_IN_RDY, 1); ex(S_OCC, 2);
    cyc();
    drv(1, 'hB3, 'hE3, 0, 0); ex(S_IN_RDY, 0); ex(S_OCC, 3);
    cyc();
    drv(0, 0, 0, 1, 0); ex(S_OCC, 3); ex(S_OUT_CTRL, 'hB0);
    cyc(); ex(S_OUT_CTRL, 'hB1);
    cyc(); ex(S_OUT_CTRL, 'hB2);
    cyc(); ex(S_OUT_VLD, 0);
    finish_test(3);

    // DEPTH=2: flush a full pipe while an input is offered.
    sel = 2'd1;
    cyc();
    drv(1, 'hF0, 'h100, 0, 0);
    cyc();
    drv(1, 'hF1, 'h101, 0, 0);
    cyc();
    drv(1, 'hF2, 'h102, 0, 0); ex(S_IN_RDY, 0); ex(S_OCC, 2); ex(S_OUT_VLD, 1);
    cyc();
    drv(1, 'hF2, 'h102, 1, 1); ex(S_OUT_VLD, 0); ex(S_IN_RDY, 1);
    cyc();
    drv(1, 'hF3, 'h103, 1, 0); ex(S_OCC, 0); ex(S_OUT_VLD, 0); ex(S_OUT_CTRL, 0);
    cyc();
    drv(0, 0, 0, 1, 0); ex(S_OUT_VLD, 0); ex(S_OCC, 1);
    cyc();
    ex(S_OUT_VLD, 1); ex(S_OUT_CTRL, 'hF3); ex(S_OUT_DATA, 'h103);
    cyc();
    finish_test(1);

    // DEPTH=1: pass-through at one entry per cycle.
    sel = 2'd0;
    cyc();
    for (int k = 0; k < 6; k++) begin
      drv(1, 8'(8'h60 + k), 128'(128'h7000 + k), 1, 0);
      ex(S_IN_RDY, 1);
      if (k > 0) begin
        ex(S_OCC, 1);
        ex(S_OUT_CTRL, 128'(8'h5F + k));
      end
      cyc();
    end
    drv(0, 0, 0, 1, 0); ex(S_OCC, 1); ex(S_OUT_CTRL, 'h65); ex(S_OUT_DATA, 'h7005);
    cyc();
    ex(S_OCC, 0);
    finish_test(6);

    // DEPTH=4: asynchronous reset with three entries held.
    sel = 2'd3;
    cyc();
    drv(1, 'h31, 'h301, 0, 0);
    cyc();
    drv(1, 'h32, 'h302, 0, 0);
    cyc();
    drv(1, 'h33, 'h303, 0, 0);
    cyc();
    drv(0, 0, 0, 0, 0);
    cyc();
    ex(S_OCC, 3); ex(S_OUT_VLD, 1); ex(S_OUT_CTRL, 'h31); ex(S_OUT_DATA, 'h301);
    cyc();
    #2 rst = 1'b0;
    sb.delete();
    ex(S_OCC, 0); ex(S_OUT_VLD, 0); ex(S_OUT_CTRL, 0); ex(S_OUT_DATA, 0); ex(S_IN_RDY, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    cyc();
    drv(1, 'h34, 'h304, 1, 0); ex(S_IN_RDY, 1); ex(S_OCC, 0);
    cyc();
    drv(0, 0, 0, 1, 0); ex(S_OUT_VLD, 0);
    cyc(); ex(S_OUT_VLD, 0);
    cyc(); ex(S_OUT_VLD, 0);
    cyc(); ex(S_OUT_VLD, 1); ex(S_OUT_CTRL, 'h34); ex(S_OUT_DATA, 'h304);
    cyc();
    finish_test(1);

    cyc();
    cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
